// File: rtl/vc_flit_queue.sv
// vc_flit_queue: NUM_VC independent flit FIFOs behind one round-robin arbitrated pop port
package types;
  typedef struct packed {
    logic [7:0]  src_id;
    logic [7:0]  dst_id;
    logic [15:0] payload;
  } flit_t;
endpackage

module vc_flit_queue #(
  parameter int NUM_VC = 2,
  parameter int DEPTH = 4,
  parameter int ALMOST_FULL_TH = DEPTH - 1,
  localparam int VC_W = NUM_VC > 1 ? $clog2(NUM_VC) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  types::flit_t        pushed_flit,
  input  logic                pushed_flit_valid,
  input  logic [VC_W-1:0]     pushed_vc,
  output logic                pushed_flit_ready,
  input  logic                poped_flit_ready,
  output logic                poped_flit_valid,
  output types::flit_t        poped_flit,
  output logic [VC_W-1:0]     poped_vc,
  output logic [NUM_VC-1:0]   vc_empty,
  output logic [NUM_VC-1:0]   vc_full,
  output logic [NUM_VC-1:0]   vc_almost_full
);
  localparam int PTR_W = $clog2(DEPTH);
  types::flit_t mem [NUM_VC][DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_VC];
  logic [PTR_W-1:0] rd_ptr [NUM_VC];
  logic [CNT_W-1:0] cnt [NUM_VC];
  logic [VC_W-1:0] rr_ptr, lock_vc, arb_vc, sel, idx;
  logic lock, found, do_push, do_pop;
  // per-VC status straight from the registered counts
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      vc_empty[v] = cnt[v] == '0;
      vc_full[v] = cnt[v] == CNT_W'(DEPTH);
      vc_almost_full[v] = cnt[v] >= CNT_W'(ALMOST_FULL_TH);
    end
  end
  // round-robin pick of the first non-empty VC from rr_ptr, overridden by the held grant while locked
  always_comb begin
    arb_vc = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = VC_W'((int'(rr_ptr) + i) % NUM_VC);
      if (!found && cnt[idx] != '0) begin
        arb_vc = idx;
        found = 1'b1;
      end
    end
    sel = lock ? lock_vc : arb_vc;
    poped_flit_valid = !(&vc_empty);
    poped_vc = poped_flit_valid ? sel : '0;
    poped_flit = poped_flit_valid ? mem[sel][rd_ptr[sel]] : '0;
    pushed_flit_ready = int'(pushed_vc) < NUM_VC && !vc_full[pushed_vc];
    do_push = pushed_flit_valid && pushed_flit_ready && !flush;
    do_pop = poped_flit_valid && poped_flit_ready && !flush;
  end
  // flit storage; contents need no reset because counts gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[pushed_vc][wr_ptr[pushed_vc]] <= pushed_flit;
  end
  // pointers, counts, round-robin pointer and grant lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v] <= '0;
      end
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_vc <= '0;
    end else if (flush) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v] <= '0;
      end
      rr_ptr <= '0;
      lock <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (do_push && pushed_vc == VC_W'(v)) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (do_pop && poped_vc == VC_W'(v)) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        cnt[v] <= cnt[v] + CNT_W'(do_push && pushed_vc == VC_W'(v)) - CNT_W'(do_pop && poped_vc == VC_W'(v));
      end
      if (do_pop) begin
        rr_ptr <= VC_W'((int'(poped_vc) + 1) % NUM_VC);
        lock <= 1'b0;
      end else if (poped_flit_valid) begin
        lock <= 1'b1;
        lock_vc <= sel;
      end
    end
  end
endmodule

// File: tb/tb_vc_flit_queue.sv
// tb_vc_flit_queue: directed vector table plus randomized run against a queue-based model
module tb_vc_flit_queue;
  localparam int NUM_VC = 2;
  localparam int DEPTH = 4;
  localparam int TH = 3;
  logic clk, rst_n, flush, pushed_flit_valid, pushed_flit_ready, poped_flit_ready, poped_flit_valid;
  types::flit_t pushed_flit, poped_flit;
  logic [0:0] pushed_vc, poped_vc;
  logic [1:0] vc_empty, vc_full, vc_almost_full;
  int checks = 0;
  int errors = 0;
  vc_flit_queue #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .ALMOST_FULL_TH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pushed_flit(pushed_flit),
    .pushed_flit_valid(pushed_flit_valid), .pushed_vc(pushed_vc), .pushed_flit_ready(pushed_flit_ready),
    .poped_flit_ready(poped_flit_ready), .poped_flit_valid(poped_flit_valid), .poped_flit(poped_flit),
    .poped_vc(poped_vc), .vc_empty(vc_empty), .vc_full(vc_full), .vc_almost_full(vc_almost_full)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic fl, pv, vc;
    logic [7:0] src;
    logic rdy, ev;
    logic [7:0] esrc;
    logic evc;
    logic [1:0] ee, ef, eaf;
    logic erdy;
  } vec_t;
  vec_t tbl[$];
  types::flit_t q[NUM_VC][$];
  int rr;
  bit locked;
  int lvc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic fl, pv, vc, input logic [7:0] src, input logic rdy, ev,
                     input logic [7:0] esrc, input logic evc, input logic [1:0] ee, ef, eaf, input logic erdy);
    vec_t t;
    t.fl = fl; t.pv = pv; t.vc = vc; t.src = src; t.rdy = rdy; t.ev = ev; t.esrc = esrc;
    t.evc = evc; t.ee = ee; t.ef = ef; t.eaf = eaf; t.erdy = erdy;
    tbl.push_back(t);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(poped_flit_valid), 0);
    chk({tag, "_flit"}, poped_flit, 0);
    chk({tag, "_vc"}, 32'(poped_vc), 0);
    chk({tag, "_empty"}, 32'(vc_empty), 32'h3);
    chk({tag, "_full"}, 32'(vc_full), 0);
    chk({tag, "_afull"}, 32'(vc_almost_full), 0);
    chk({tag, "_ready"}, 32'(pushed_flit_ready), 1);
  endtask
  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) q[v].delete();
    rr = 0;
    locked = 0;
    lvc = 0;
  endtask
  task automatic mstep(input logic fl, pv, vc, input types::flit_t f, input logic rdy);
    bit ev, found, erdy;
    int sel;
    logic [1:0] ee, ef, eaf;
    types::flit_t ef_flit;
    flush = fl; pushed_flit_valid = pv; pushed_vc = vc; pushed_flit = f; poped_flit_ready = rdy;
    #1;
    ev = 0; found = 0; sel = 0;
    for (int v = 0; v < NUM_VC; v++) begin
      ee[v] = q[v].size() == 0;
      ef[v] = q[v].size() == DEPTH;
      eaf[v] = q[v].size() >= TH;
      if (q[v].size() != 0) ev = 1;
    end
    if (locked) sel = lvc;
    else for (int i = 0; i < NUM_VC; i++) if (!found && q[(rr + i) % NUM_VC].size() != 0) begin
      sel = (rr + i) % NUM_VC;
      found = 1;
    end
    ef_flit = ev ? q[sel][0] : '0;
    erdy = q[int'(vc)].size() < DEPTH;
    chk("m_valid", 32'(poped_flit_valid), 32'(ev));
    chk("m_flit", poped_flit, ef_flit);
    chk("m_vc", 32'(poped_vc), ev ? sel : 0);
    chk("m_empty", 32'(vc_empty), 32'(ee));
    chk("m_full", 32'(vc_full), 32'(ef));
    chk("m_afull", 32'(vc_almost_full), 32'(eaf));
    chk("m_ready", 32'(pushed_flit_ready), 32'(erdy));
    @(posedge clk);
    if (fl) model_reset();
    else begin
      if (ev && rdy) begin
        void'(q[sel].pop_front());
        rr = (sel + 1) % NUM_VC;
        locked = 0;
      end else if (ev) begin
        locked = 1;
        lvc = sel;
      end
      if (pv && erdy) q[int'(vc)].push_back(f);
    end
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; flush = 0; pushed_flit_valid = 0; pushed_vc = 0; pushed_flit = '0; poped_flit_ready = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    add(0,0,0,8'h00,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,0,1,8'h00,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,0,8'h01,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,0,0,8'h00,0, 1,8'h01,0,2'b10,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h01,0,2'b10,2'b00,2'b00,1);
    add(0,0,0,8'h00,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,1,8'h10,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,1,8'h11,0, 1,8'h10,1,2'b01,2'b00,2'b00,1);
    add(0,1,1,8'h12,0, 1,8'h10,1,2'b01,2'b00,2'b00,1);
    add(0,1,1,8'h13,0, 1,8'h10,1,2'b01,2'b00,2'b10,1);
    add(0,1,1,8'h14,0, 1,8'h10,1,2'b01,2'b10,2'b10,0);
    add(0,0,0,8'h00,0, 1,8'h10,1,2'b01,2'b10,2'b10,1);
    add(0,0,0,8'h00,1, 1,8'h10,1,2'b01,2'b10,2'b10,1);
    add(0,0,0,8'h00,1, 1,8'h11,1,2'b01,2'b00,2'b10,1);
    add(0,0,0,8'h00,1, 1,8'h12,1,2'b01,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h13,1,2'b01,2'b00,2'b00,1);
    add(0,0,0,8'h00,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,0,8'h20,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,0,8'h21,0, 1,8'h20,0,2'b10,2'b00,2'b00,1);
    add(0,1,1,8'h30,0, 1,8'h20,0,2'b10,2'b00,2'b00,1);
    add(0,1,1,8'h31,0, 1,8'h20,0,2'b00,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h20,0,2'b00,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h30,1,2'b00,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h21,0,2'b00,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h31,1,2'b01,2'b00,2'b00,1);
    add(0,0,0,8'h00,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,1,8'h30,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,0,8'h22,0, 1,8'h30,1,2'b01,2'b00,2'b00,1);
    add(0,0,0,8'h00,0, 1,8'h30,1,2'b00,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h30,1,2'b00,2'b00,2'b00,1);
    add(0,0,0,8'h00,1, 1,8'h22,0,2'b10,2'b00,2'b00,1);
    add(0,0,0,8'h00,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,0,8'h40,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    add(0,1,1,8'h41,0, 1,8'h40,0,2'b10,2'b00,2'b00,1);
    add(0,1,0,8'h42,0, 1,8'h40,0,2'b00,2'b00,2'b00,1);
    add(1,1,1,8'h43,1, 1,8'h40,0,2'b00,2'b00,2'b00,1);
    add(0,0,0,8'h00,0, 0,8'h00,0,2'b11,2'b00,2'b00,1);
    for (int i = 0; i < tbl.size(); i++) begin
      flush = tbl[i].fl; pushed_flit_valid = tbl[i].pv; pushed_vc = tbl[i].vc;
      pushed_flit = '{src_id: tbl[i].src, dst_id: 8'h00, payload: 16'h0000};
      poped_flit_ready = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d_valid", i), 32'(poped_flit_valid), 32'(tbl[i].ev));
      chk($sformatf("t%0d_flit", i), poped_flit, {tbl[i].esrc, 24'h0});
      chk($sformatf("t%0d_vc", i), 32'(poped_vc), 32'(tbl[i].evc));
      chk($sformatf("t%0d_empty", i), 32'(vc_empty), 32'(tbl[i].ee));
      chk($sformatf("t%0d_full", i), 32'(vc_full), 32'(tbl[i].ef));
      chk($sformatf("t%0d_afull", i), 32'(vc_almost_full), 32'(tbl[i].eaf));
      chk($sformatf("t%0d_ready", i), 32'(pushed_flit_ready), 32'(tbl[i].erdy));
      @(posedge clk);
      @(negedge clk);
    end
    model_reset();
    for (int i = 0; i < 3; i++) mstep(0, 1, 1'(i), types::flit_t'($urandom), 0);
    flush = 0; pushed_flit_valid = 1; pushed_vc = 0; pushed_flit = types::flit_t'($urandom);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++)
      mstep($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom), types::flit_t'($urandom),
            $urandom_range(0, 9) < 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
